// File: rtl/data_memory_sized_if.sv
// Request/response bundle between the datapath memory stage and data_memory_sized.
// The requester drives the request fields; the memory drives ready and the response.
interface data_memory_sized_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [63:0]       resp_rdata;
    logic              resp_write;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata, resp_write
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata, resp_write
    );
endinterface

// File: rtl/data_memory_sized.sv
// Byte-addressable little-endian data memory with sized, sign/zero-extended accesses,
// a single-outstanding valid/ready request port and a configurable read latency.
module data_memory_sized #(
    parameter int ADDR_W      = 64,
    parameter int DEPTH_BYTES = 256,
    parameter int READ_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    data_memory_sized_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int AW1   = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_L = AW1'(DEPTH_BYTES);
    localparam bit   MULTI_CYCLE = (READ_LAT > 1);
    localparam logic [1:0] CNT_INIT = MULTI_CYCLE ? 2'(READ_LAT - 2) : 2'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [7:0]       mem [DEPTH_BYTES];
    state_t           state_r;
    logic [1:0]       cnt_r;
    logic [63:0]      pend_rdata_r;
    logic             resp_valid_r;
    logic             resp_err_r;
    logic             resp_write_r;
    logic [63:0]      resp_rdata_r;

    logic [3:0]       size_bytes_s;
    logic [ADDR_W:0]  end_addr_s;
    logic             misaligned_s;
    logic             out_of_range_s;
    logic             legal_s;
    logic             legal_load_s;
    logic             accept_s;
    logic [IDX_W-1:0] idx_s;
    logic [63:0]      raw_s;
    logic [63:0]      load_s;

    assign bus.req_ready  = (state_r == IDLE) && !reset;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_write = resp_write_r;
    assign bus.resp_rdata = resp_rdata_r;

    // Legality check, little-endian read snapshot and sign/zero extension of the request
    always_comb begin
        size_bytes_s   = 4'd1 << bus.req_size;
        // end address is one bit wider than the address so a high address cannot wrap into range
        end_addr_s     = {1'b0, bus.req_addr} + AW1'(size_bytes_s);
        misaligned_s   = (bus.req_addr[2:0] & (3'(size_bytes_s) - 3'd1)) != 3'd0;
        out_of_range_s = end_addr_s > DEPTH_L;
        legal_s        = !misaligned_s && !out_of_range_s;
        legal_load_s   = legal_s && !bus.req_write;
        accept_s       = bus.req_valid && bus.req_ready;
        idx_s          = bus.req_addr[IDX_W-1:0];
        raw_s          = 64'd0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < size_bytes_s) begin
                raw_s[8*k +: 8] = mem[idx_s + IDX_W'(k)];
            end else begin
                raw_s[8*k +: 8] = 8'd0;
            end
        end
        case (bus.req_size)
            2'd0:    load_s = bus.req_unsigned ? {56'd0, raw_s[7:0]}
                                               : {{56{raw_s[7]}}, raw_s[7:0]};
            2'd1:    load_s = bus.req_unsigned ? {48'd0, raw_s[15:0]}
                                               : {{48{raw_s[15]}}, raw_s[15:0]};
            2'd2:    load_s = bus.req_unsigned ? {32'd0, raw_s[31:0]}
                                               : {{32{raw_s[31]}}, raw_s[31:0]};
            default: load_s = raw_s;
        endcase
    end

    // Byte-lane store commit at the acceptance edge; contents survive reset
    always_ff @(posedge clk) begin
        if (accept_s && bus.req_write && legal_s) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < size_bytes_s) begin
                    mem[idx_s + IDX_W'(k)] <= bus.req_wdata[8*k +: 8];
                end
            end
        end
    end

    // Request sequencing: IDLE -> (WAIT) -> RESP -> IDLE, driving the registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= 2'd0;
            pend_rdata_r <= 64'd0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_write_r <= 1'b0;
            resp_rdata_r <= 64'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    resp_valid_r <= 1'b0;
                    cnt_r        <= CNT_INIT;
                    if (accept_s) begin
                        if (legal_load_s && MULTI_CYCLE) begin
                            state_r      <= WAIT;
                            pend_rdata_r <= load_s;
                        end else begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= !legal_s;
                            resp_write_r <= bus.req_write;
                            resp_rdata_r <= legal_load_s ? load_s : 64'd0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_r == 2'd0) begin
                        state_r      <= RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_write_r <= 1'b0;
                        resp_rdata_r <= pend_rdata_r;
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                RESP: begin
                    resp_valid_r <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end
endmodule
